// File: rtl/data_memory_unit.sv
// Byte-addressable data memory for an RV32I load/store stage.
// One request per cycle, registered load result one cycle later.
module data_memory_unit #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        DMWr,
  input  logic [2:0]  DMCtrl,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        fault
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_X
  } size_e;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  size_e         size;
  logic          sext;
  logic          ctrl_ok;
  logic          align_ok;
  logic          range_ok;
  logic          legal;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   word;
  logic [7:0]    bsel;
  logic [15:0]   hsel;
  logic [31:0]   ldata;

  assign idx  = addr[AW+1:2];
  assign lane = addr[1:0];
  assign word = mem[idx];

  always_comb begin
    size = SZ_X;
    sext = 1'b0;
    case (DMCtrl)
      3'b000: begin size = SZ_B; sext = 1'b1; end
      3'b001: begin size = SZ_H; sext = 1'b1; end
      3'b010: begin size = SZ_W; sext = 1'b0; end
      3'b100: begin size = SZ_B; sext = 1'b0; end
      3'b101: begin size = SZ_H; sext = 1'b0; end
      default: begin size = SZ_X; sext = 1'b0; end
    endcase
  end

  // unsigned variants exist only for loads
  assign ctrl_ok  = (size != SZ_X) && !(DMWr && DMCtrl[2]);
  assign range_ok = ~|addr[31:AW+2];

  always_comb begin
    align_ok = 1'b1;
    case (size)
      SZ_H:    align_ok = ~addr[0];
      SZ_W:    align_ok = (addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
  end

  assign legal = ctrl_ok & align_ok & range_ok;

  always_comb begin
    be    = 4'b0000;
    wdata = wr_data;
    case (size)
      SZ_B: begin
        be    = 4'b0001 << lane;
        wdata = {4{wr_data[7:0]}};
      end
      SZ_H: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wr_data[15:0]}};
      end
      SZ_W: begin
        be    = 4'b1111;
        wdata = wr_data;
      end
      default: begin
        be    = 4'b0000;
        wdata = wr_data;
      end
    endcase
  end

  always_comb begin
    bsel  = word[{lane, 3'b000} +: 8];
    hsel  = addr[1] ? word[31:16] : word[15:0];
    ldata = word;
    case (size)
      SZ_B:    ldata = {{24{sext & bsel[7]}}, bsel};
      SZ_H:    ldata = {{16{sext & hsel[15]}}, hsel};
      default: ldata = word;
    endcase
  end

  // contents survive reset; only the response path is cleared
  always_ff @(posedge clk) begin
    if (!rst && req_valid && DMWr && legal) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      fault    <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      fault    <= 1'b0;
      if (req_valid) begin
        if (!legal) begin
          fault <= 1'b1;
          if (!DMWr) rd_data <= '0;
        end else if (!DMWr) begin
          rd_valid <= 1'b1;
          rd_data  <= ldata;
        end
      end
    end
  end

endmodule

// File: doc/data_memory_unit.md
DATA_MEMORY_UNIT -- requirements
Module: data_memory_unit

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit words stored; it SHALL be a power of two, minimum 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req_valid, input, 1 bit: an access is presented this cycle.
REQ-005 The block SHALL have port DMWr, input, 1 bit: 1 = store, 0 = load; ignored when req_valid=0 (may be X).
REQ-006 The block SHALL have port DMCtrl, input, 3 bits: access size/sign, RV32I funct3 encoding; ignored when req_valid=0.
REQ-007 The block SHALL have port addr, input, 32 bits: byte address (ALU result).
REQ-008 The block SHALL have port wr_data, input, 32 bits: store data (rs2), used in its low byte, halfword or full word.
REQ-009 The block SHALL have port rd_data, output, 32 bits: registered, extended load result.
REQ-010 The block SHALL have port rd_valid, output, 1 bit: pulses 1 the cycle rd_data holds a load result.
REQ-011 The block SHALL have port fault, output, 1 bit: pulses 1 the cycle after an accepted illegal access.

Function
REQ-012 Legal loads SHALL be DMCtrl 000 LB, 001 LH, 010 LW, 100 LBU and 101 LHU; legal stores SHALL be DMCtrl 000 SB, 001 SH and 010 SW.
REQ-013 An access SHALL be illegal for any other DMCtrl code; a halfword access with addr[0]=1; a word access with addr[1:0]!=0; or addr[31:2] >= DEPTH_WORDS.
REQ-014 The word index SHALL be addr[log2(DEPTH_WORDS)+1:2], and the byte lane SHALL be addr[1:0].
REQ-015 A legal store SHALL write only the addressed lanes at the clock edge where req_valid=1: SB writes 1 lane, SH writes lanes {addr[1],0} and {addr[1],1}, SW writes 4 lanes; the other lanes SHALL be unchanged.
REQ-016 An illegal store SHALL not modify memory.
REQ-017 A load SHALL have latency 1: a load accepted in cycle N produces rd_data and rd_valid=1 (or fault=1) in cycle N+1.
REQ-018 A load result SHALL be formatted as follows: LB and LH sign-extend bit 7 or bit 15 of the selected field; LBU and LHU zero-extend; LW returns the word unchanged.
REQ-019 An illegal load SHALL give rd_valid=0, fault=1 and rd_data=0 in cycle N+1.
REQ-020 An illegal store SHALL give fault=1 in cycle N+1; a legal store SHALL give rd_valid=0 and fault=0 in cycle N+1.
REQ-021 rd_data SHALL hold its last value while rd_valid=0, except in the illegal-load case of REQ-019.
REQ-022 Read-after-write: a load in cycle N+1 to a word stored in cycle N SHALL return the stored data.
REQ-023 The block SHALL accept a new request every cycle with no stall; back-to-back loads SHALL produce consecutive rd_valid pulses.
REQ-024 A load/store pair in consecutive cycles to the same word SHALL follow program order: the load sees the store only if the store came first.
REQ-025 With req_valid=0, memory SHALL be unchanged and the next cycle SHALL have rd_valid=0 and fault=0.

Reset
REQ-026 While rst=1, rd_data=0, rd_valid=0 and fault=0 at the next edge, and any request presented in the same cycle SHALL be discarded: no write, no response.
REQ-027 Reset SHALL not clear memory contents; contents are undefined until written.
REQ-028 A load accepted in the cycle before rst rises SHALL produce no rd_valid pulse if rst=1 at the edge where its result would register.

Verification
REQ-029 SW 0x80FF7F01 @0x10, then LB @0x10/0x11/0x12/0x13 SHALL return 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80, each rd_valid one cycle later.
REQ-030 After REQ-029: LBU @0x13 -> 0x00000080; LH @0x12 -> 0xFFFF80FF; LHU @0x12 -> 0x000080FF; LW @0x10 -> 0x80FF7F01.
REQ-031 SB 0xAA @0x21 then SH 0x1234 @0x22 over a prior SW 0 @0x20, followed by LW @0x20 SHALL return 0x1234AA00.
REQ-032 LW @0x12, SH @0x13, DMCtrl=011 and addr=DEPTH_WORDS*4 SHALL each give fault=1, rd_valid=0, rd_data=0 and no memory change (an LW check confirms the old values).
REQ-033 A back-to-back SW 0xDEADBEEF @0x40 then LW @0x40 SHALL return 0xDEADBEEF in the cycle after the load.
REQ-034 An LW accepted, then rst=1 on the next cycle SHALL give no rd_valid and rd_data=0; a prior store SHALL still be readable after reset is released.
